// File: rtl/booth_seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, with
// start/ready request handshake and valid/ready result handshake.
module booth_seq_divider #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_ready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic                  o_div_by_zero,
  output logic                  o_overflow
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0]  ONE_W    = W'(1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  // Partial remainder never exceeds the divisor magnitude, so its top bit is
  // only needed transiently in the shifted/trial values below.
  logic [W-1:0]  prem_reg;
  logic [W-1:0]  quo_reg;
  logic [W-1:0]  dvs_reg;
  logic          q_sign_reg;
  logic          r_sign_reg;
  logic          ovf_reg;

  logic          dividend_neg;
  logic          divisor_neg;
  logic [W-1:0]  dividend_mag;
  logic [W-1:0]  divisor_mag;
  logic          divisor_zero;
  logic          is_overflow;
  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic [W-1:0]  quo_fixed;
  logic [W-1:0]  rem_fixed;

  always_comb begin
    dividend_neg = i_signed & i_dividend[W-1];
    divisor_neg  = i_signed & i_divisor[W-1];
    dividend_mag = dividend_neg ? (~i_dividend + ONE_W) : i_dividend;
    divisor_mag  = divisor_neg  ? (~i_divisor  + ONE_W) : i_divisor;
    divisor_zero = (i_divisor == '0);
    is_overflow  = i_signed && (i_dividend == MOST_NEG) && (i_divisor == '1);
    shifted      = {prem_reg, quo_reg[W-1]};
    trial        = shifted - {1'b0, dvs_reg};
    quo_fixed    = q_sign_reg ? (~quo_reg  + ONE_W) : quo_reg;
    rem_fixed    = r_sign_reg ? (~prem_reg + ONE_W) : prem_reg;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      prem_reg      <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      q_sign_reg    <= 1'b0;
      r_sign_reg    <= 1'b0;
      ovf_reg       <= 1'b0;
      o_ready       <= 1'b1;
      o_valid       <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            o_ready <= 1'b0;
            if (divisor_zero) begin
              o_quotient    <= '1;
              o_remainder   <= i_dividend;
              o_div_by_zero <= 1'b1;
              o_overflow    <= 1'b0;
              o_valid       <= 1'b1;
              state_reg     <= DONE;
            end else begin
              quo_reg    <= dividend_mag;
              dvs_reg    <= divisor_mag;
              q_sign_reg <= dividend_neg ^ divisor_neg;
              r_sign_reg <= dividend_neg;
              ovf_reg    <= is_overflow;
              prem_reg   <= '0;
              cnt_reg    <= CNT_LOAD;
              state_reg  <= CALC;
            end
          end
        end
        CALC: begin
          // Dividend bits shift out of quo_reg while quotient bits shift in.
          if (!trial[W]) begin
            prem_reg <= trial[W-1:0];
            quo_reg  <= {quo_reg[W-2:0], 1'b1};
          end else begin
            prem_reg <= shifted[W-1:0];
            quo_reg  <= {quo_reg[W-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          o_quotient    <= quo_fixed;
          o_remainder   <= rem_fixed;
          o_div_by_zero <= 1'b0;
          o_overflow    <= ovf_reg;
          o_valid       <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid   <= 1'b0;
            o_ready   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          o_valid   <= 1'b0;
          o_ready   <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Self-checking bench for booth_seq_divider: directed table, hand-written
// handshake/reset sequences, and randomized operands against an integer model.
module tb_booth_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sgn;
  logic [7:0] dvd;
  logic [7:0] dvs;
  logic       rdy_in;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_quotient;
  logic [7:0] o_remainder;
  logic       o_div_by_zero;
  logic       o_overflow;

  int vectors;
  int miscompares;

  booth_seq_divider #(.DATA_WIDTH(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_signed      (sgn),
    .i_dividend    (dvd),
    .i_divisor     (dvs),
    .o_ready       (o_ready),
    .o_valid       (o_valid),
    .i_ready       (rdy_in),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero),
    .o_overflow    (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Golden divider from plain integer arithmetic (SV division truncates to zero).
  function automatic void model(input logic s, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov);
    int sa;
    int sb;
    int qi;
    int ri;
    dz = 1'b0;
    ov = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 8'h00) begin
      q  = 8'hFF;
      r  = a;
      dz = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      if (sa == -128 && sb == -1) ov = 1'b1;
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[7:0];
      r  = ri[7:0];
    end
  endfunction

  // One full transaction: wait for ready, request, count edges to valid, handshake.
  task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic dz, output logic ov, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", 32'(o_ready), 32'd1);
    start = 1'b1;
    sgn   = s;
    dvd   = a;
    dvs   = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    sgn   = 1'($urandom);
    dvd   = 8'($urandom);
    dvs   = 8'($urandom);
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("valid_seen", 32'(o_valid), 32'd1);
    q  = o_quotient;
    r  = o_remainder;
    dz = o_div_by_zero;
    ov = o_overflow;
    rdy_in = 1'b1;
    @(negedge clk);
    rdy_in = 1'b0;
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] v;
    case ($urandom_range(0, 7))
      0:       v = 8'h00;
      1:       v = 8'h01;
      2:       v = 8'h7F;
      3:       v = 8'h80;
      4:       v = 8'hFF;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    vec_t       tbl[9];
    logic [7:0] q, r, eq, er;
    logic       dz, ov, edz, eov;
    int         lat;
    int         n;
    logic       s;
    logic [7:0] a, b;

    vectors     = 0;
    miscompares = 0;
    start  = 1'b0;
    sgn    = 1'b0;
    dvd    = 8'h00;
    dvs    = 8'h00;
    rdy_in = 1'b0;

    tbl[0] = '{1'b0, 8'd200, 8'd7,   8'h1C, 8'h04, 1'b0, 1'b0, 9};
    tbl[1] = '{1'b1, 8'h9C,  8'h07,  8'hF2, 8'hFE, 1'b0, 1'b0, 9};
    tbl[2] = '{1'b1, 8'h64,  8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 9};
    tbl[3] = '{1'b0, 8'h55,  8'h00,  8'hFF, 8'h55, 1'b1, 1'b0, 0};
    tbl[4] = '{1'b1, 8'h55,  8'h00,  8'hFF, 8'h55, 1'b1, 1'b0, 0};
    tbl[5] = '{1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 9};
    tbl[6] = '{1'b0, 8'h80,  8'hFF,  8'h00, 8'h80, 1'b0, 1'b0, 9};
    tbl[7] = '{1'b0, 8'd9,   8'd3,   8'h03, 8'h00, 1'b0, 1'b0, 9};
    tbl[8] = '{1'b1, 8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 9};

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_quot",  32'(o_quotient), 32'd0);
    check("rst_rem",   32'(o_remainder), 32'd0);
    check("rst_flags", 32'({o_div_by_zero, o_overflow}), 32'd0);

    // Directed table; lat counts edges after the accept edge (0 = next cycle).
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, q, r, dz, ov, lat);
      check($sformatf("tbl%0d_quot", i), 32'(q), 32'(tbl[i].q));
      check($sformatf("tbl%0d_rem", i),  32'(r), 32'(tbl[i].r));
      check($sformatf("tbl%0d_dbz", i),  32'(dz), 32'(tbl[i].dz));
      check($sformatf("tbl%0d_ovf", i),  32'(ov), 32'(tbl[i].ov));
      check($sformatf("tbl%0d_lat", i),  32'(lat), 32'(tbl[i].lat));
    end

    // Backpressure, plus i_start held high through CALC and DONE.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; dvd = 8'd200; dvs = 8'd7;
    @(posedge clk);
    @(negedge clk);
    dvd = 8'h11; dvs = 8'h01;
    for (int i = 0; i < 3; i++) begin
      check("calc_not_ready", 32'(o_ready), 32'd0);
      @(negedge clk);
    end
    n = 0;
    while (!o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_quot",  32'(o_quotient), 32'h1C);
      check("bp_rem",   32'(o_remainder), 32'h04);
      @(negedge clk);
    end
    rdy_in = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    rdy_in = 1'b0;
    check("hs_start_ignored_ready", 32'(o_ready), 32'd1);
    check("hs_valid_low", 32'(o_valid), 32'd0);
    check("hs_quot_held", 32'(o_quotient), 32'h1C);
    check("hs_rem_held",  32'(o_remainder), 32'h04);

    // Reset in the fourth CALC cycle.
    @(negedge clk);
    start = 1'b1; sgn = 1'b1; dvd = 8'h9C; dvs = 8'h07;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready", 32'(o_ready), 32'd1);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_quot",  32'(o_quotient), 32'd0);
    check("midrst_rem",   32'(o_remainder), 32'd0);
    check("midrst_flags", 32'({o_div_by_zero, o_overflow}), 32'd0);
    run_op(1'b0, 8'd9, 8'd3, q, r, dz, ov, lat);
    check("after_rst_quot", 32'(q), 32'd3);
    check("after_rst_rem",  32'(r), 32'd0);

    // Randomized operands against the integer model.
    for (int i = 0; i < 2000; i++) begin
      s = 1'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      model(s, a, b, eq, er, edz, eov);
      run_op(s, a, b, q, r, dz, ov, lat);
      check($sformatf("rnd%0d_quot s=%0d %0h/%0h", i, s, a, b), 32'(q), 32'(eq));
      check($sformatf("rnd%0d_rem s=%0d %0h/%0h", i, s, a, b),  32'(r), 32'(er));
      check($sformatf("rnd%0d_dbz", i), 32'(dz), 32'(edz));
      check($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(eov));
      check($sformatf("rnd%0d_lat", i), 32'(lat), (b == 8'h00) ? 32'd0 : 32'd9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
